// File: rtl/uart_pixel_packer_pkg.sv
// Shared types and constants for the UART-to-frame-buffer pixel path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package elephoto_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR1    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int PIX_W  = 12;
  localparam int ADDR_W = 15;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  // Pixels per frame, truncated to the pixel-index width.
  function automatic logic [ADDR_W-1:0] pix_total(input int w, input int h);
    return ADDR_W'(w * h);
  endfunction

endpackage

// File: rtl/uart_pixel_packer_if.sv
// Byte stream in from the UART receiver and pixel strobe out to the RAM controller.
// Latency: n/a (wiring only).
// Backpressure: none; both streams are fire-and-forget strobes.
interface uart_pixel_packer_if;
  import elephoto_pkg::*;

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             rx_valid;
  logic [PIX_W-1:0] rx_data;

  modport master (output byte_valid, output byte_data, input rx_valid, input rx_data);
  modport slave  (input byte_valid, input byte_data, output rx_valid, output rx_data);

endinterface

// File: rtl/uart_pixel_packer_emit_queue.sv
// 2-entry pixel FIFO that releases its head as single-cycle rx_valid strobes paced by MIN_GAP.
// Latency: a pixel pushed into an empty, unpaced queue strobes two cycles after the push.
// Backpressure: none upstream; full means a push this cycle would be lost, flush empties it and cancels the strobe.
module pix_emit_queue
  import elephoto_pkg::*;
#(
  parameter int MIN_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PIX_W-1:0] data_in,
  input  logic             flush,
  output logic             rx_valid,
  output logic [PIX_W-1:0] rx_data,
  output logic             full
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);

  logic [PIX_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_ok;
  logic             deq;
  logic             wr_en;

  // Pop the head once the pacing window since the previous strobe has elapsed; a pop frees a slot for a same-cycle push.
  always_comb begin
    gap_ok = (gap_cnt >= GAP_W'(MIN_GAP));
    deq    = (count != 2'd0) && gap_ok;
    full   = (count == 2'd2) && !deq;
    wr_en  = push && !full;
  end

  // Storage, pointers, saturating pacing counter and the registered pixel strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      gap_cnt  <= GAP_W'(MIN_GAP);
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (flush) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      rx_valid <= 1'b0;
      if (!gap_ok) gap_cnt <= gap_cnt + GAP_W'(1);
    end else begin
      rx_valid <= deq;
      if (deq) begin
        rx_data <= mem[rd_ptr];
        rd_ptr  <= ~rd_ptr;
        gap_cnt <= GAP_W'(1);
      end else if (!gap_ok) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
      if (wr_en) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ~wr_ptr;
      end
      count <= count + {1'b0, wr_en} - {1'b0, deq};
    end
  end

endmodule

// File: rtl/uart_pixel_packer.sv
// Frames the UART byte stream (HDR0 HDR1 payload), unpacks 3 bytes into 2 BGR pixels and counts them to W*H.
// Latency: a pixel strobes on rx_valid two cycles after its last byte when the pacing window is open.
// Backpressure: none upstream; a third pending pixel or a byte gap of TIMEOUT cycles aborts the frame with frame_error.
module uart_pixel_packer
  import elephoto_pkg::*;
#(
  parameter int         W       = 50,
  parameter int         H       = 40,
  parameter logic [7:0] HDR0    = HDR0_DEF,
  parameter logic [7:0] HDR1    = HDR1_DEF,
  parameter int         TIMEOUT = 1200000,
  parameter int         MIN_GAP = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture_en,
  uart_pixel_packer_if.slave  bus,
  output logic [ADDR_W-1:0]   pix_idx,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_error
);

  localparam logic [ADDR_W-1:0] LAST_PIX = pix_total(W, H) - ADDR_W'(1);
  localparam int                TMO_W    = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [1:0]       phase;
  logic [7:0]       b0;
  logic [3:0]       b1_lo;
  logic [TMO_W-1:0] tmo_cnt;

  logic             in_frame;
  logic             push;
  logic [PIX_W-1:0] push_data;
  logic             q_full;
  logic             q_valid;
  logic [PIX_W-1:0] q_data;
  logic             overflow;
  logic             tmo_hit;
  logic             abort;
  logic             done_hit;
  logic             flush;

  // Pixel assembly, frame-ending events and the queue flush they imply.
  always_comb begin
    in_frame  = (state == ST_HDR1) || (state == ST_PAYLOAD);
    push      = (state == ST_PAYLOAD) && bus.byte_valid && capture_en && (phase != 2'd0);
    push_data = (phase == 2'd1) ? {b0, bus.byte_data[7:4]} : {b1_lo, bus.byte_data};
    overflow  = push && q_full;
    tmo_hit   = in_frame && !bus.byte_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    abort     = in_frame && !capture_en;
    done_hit  = (state == ST_PAYLOAD) && q_valid && (pix_idx == LAST_PIX);
    flush     = abort || done_hit || overflow || tmo_hit;
  end

  assign bus.rx_valid = q_valid;
  assign bus.rx_data  = q_data;

  pix_emit_queue #(
    .MIN_GAP (MIN_GAP)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .data_in  (push_data),
    .flush    (flush),
    .rx_valid (q_valid),
    .rx_data  (q_data),
    .full     (q_full)
  );

  // Frame FSM with registered status outputs, byte phase and inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase       <= 2'd0;
      b0          <= '0;
      b1_lo       <= '0;
      tmo_cnt     <= '0;
      pix_idx     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!in_frame || bus.byte_valid || tmo_hit) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if ((state == ST_PAYLOAD) && q_valid) pix_idx <= pix_idx + ADDR_W'(1);

      case (state)
        ST_IDLE: begin
          if (capture_en && bus.byte_valid && (bus.byte_data == HDR0)) begin
            state       <= ST_HDR1;
            busy        <= 1'b1;
            frame_error <= 1'b0;
            pix_idx     <= '0;
          end
        end
        ST_HDR1: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tmo_hit) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end else if (bus.byte_valid) begin
            if (bus.byte_data == HDR1) begin
              state <= ST_PAYLOAD;
              phase <= 2'd0;
            end else if (bus.byte_data != HDR0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_PAYLOAD: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (done_hit) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (overflow || tmo_hit) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end else if (bus.byte_valid) begin
            case (phase)
              2'd0:    begin b0    <= bus.byte_data;      phase <= 2'd1; end
              2'd1:    begin b1_lo <= bus.byte_data[3:0]; phase <= 2'd2; end
              default: phase <= 2'd0;
            endcase
          end
        end
        ST_DONE: begin
          if (!capture_en) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_pixel_packer.md
Name: uart_pixel_packer

Overview:
- Upstream stage of the frame-buffer RAM controller: converts the UART receiver's byte stream into 12-bit BGR pixels, one rx_valid pulse per pixel.
- Detects the frame header, unpacks 3 bytes into 2 pixels and counts pixels to W*H.
- Paces pulses so the RAM's capture-then-write sequence is never overrun.
- Flags frame completion, timeouts and overflows to the top-level state machine.

Parameters:
- W, 50, image width in pixels.
- H, 40, image height in pixels; W*H must be even, ≤ 32767.
- HDR0, 8'hAA, first header byte.
- HDR1, 8'h55, second header byte.
- TIMEOUT, 1200000, clk cycles without a byte inside a frame before abort.
- MIN_GAP, 2, minimum clk cycles between consecutive rx_valid rising edges, ≥ 2.

Ports:
- Clock and reset:
  - clk  in  1  system clock, all logic on posedge.
  - rst_n  in  1  asynchronous active-low reset.
- Control and byte input:
  - capture_en  in  1  high while the top state is receive (8'h02); low aborts or rearms.
  - byte_valid  in  1  one-cycle strobe from the UART receiver.
  - byte_data  in  8  received byte, valid with byte_valid.
- Pixel output:
  - rx_valid  out  1  one-cycle pixel strobe to the RAM controller.
  - rx_data  out  12  pixel BGR, valid while rx_valid is high.
- Status:
  - pix_idx  out  15  count of pixels emitted in the current frame.
  - busy  out  1  high in HDR1 or PAYLOAD.
  - frame_done  out  1  one-cycle pulse after the last pixel is emitted.
  - frame_error  out  1  sticky; cleared on the next accepted HDR0 or by reset.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; queue empty; byte phase 0; timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, HDR1, PAYLOAD, DONE.
  - IDLE:
    - byte_valid with capture_en and byte == HDR0 → HDR1; clear frame_error and pix_idx.
    - Any other byte is ignored.
  - HDR1:
    - byte == HDR1 → PAYLOAD, byte phase 0.
    - byte == HDR0 → stay in HDR1.
    - Any other byte → IDLE, no error.
  - PAYLOAD unpacking, bytes B0, B1, B2:
    - pixel0 = {B0, B1[7:4]}, enqueued on the cycle B1 arrives.
    - pixel1 = {B1[3:0], B2}, enqueued on the cycle B2 arrives.
    - Phase wraps 2 → 0.
  - PAYLOAD → DONE when the pixel with index PIX_TOTAL-1 has been emitted (not merely enqueued).
    - frame_done pulses on the cycle DONE is entered.
  - DONE:
    - Bytes are ignored.
    - capture_en low → IDLE; pix_idx holds until the next HDR0.
- Emit queue:
  - 2 entries.
  - Head is emitted as rx_valid=1 for exactly one cycle.
  - A new emission is allowed only if ≥ MIN_GAP cycles have passed since the previous rx_valid rising edge.
  - pix_idx increments on the cycle after each emission.
  - Enqueue and dequeue in the same cycle are legal; occupancy is unchanged.
- Overflow: enqueue while 2 entries are held and none is dequeuing this cycle → frame_error=1, queue flushed, FSM → IDLE.
- Timeout:
  - Counter clears on each byte_valid and increments in HDR1/PAYLOAD otherwise.
  - Reaching TIMEOUT → frame_error=1, queue flushed, FSM → IDLE.
- capture_en falling in HDR1/PAYLOAD → IDLE, queue flushed, no error, no frame_done.
- Reset mid-frame: immediate return to reset state; pending pixels are dropped.
- Widths:
  - pix_idx 15 bits, compared against PIX_TOTAL-1 = W*H-1.
  - Timeout counter sized by $clog2(TIMEOUT+1).

Decomposition:
- Package elephoto_pkg holds:
  - FSM state enum (2-bit).
  - PIX_W = 12, ADDR_W = 15.
  - Header constants HDR0/HDR1.
  - Function pix_total(W,H).
- Sub-module pix_emit_queue (2-entry FIFO plus MIN_GAP pacing counter), with ports:
  - push/data_in
  - pop-side rx_valid/rx_data
  - full, flush

Test Plan:
- Bytes AA 55 12 34 56 → rx_valid pulses with rx_data 12'h123 then 12'h456, pulses ≥ 2 cycles apart, pix_idx = 2.
- Full frame: header + 3000 bytes (W=50, H=40) → exactly 2000 pulses; frame_done one pulse after pulse 2000; pix_idx = 2000; further bytes produce no pulses.
- Header AA AA 55 → PAYLOAD entered. Header AA 13 → back to IDLE, no error; following payload bytes ignored.
- Byte stream stalls 1200000 cycles mid-payload → frame_error = 1, busy = 0; next AA clears frame_error.
- Bytes B1 and B2 on back-to-back cycles → both pixels emitted with rising-edge gap = MIN_GAP, no overflow. A third push while full with no pop → frame_error = 1.
- capture_en low after 10 pixels → IDLE, no frame_done. rst_n low mid-frame → all outputs 0 asynchronously.
